led_matrix_scanner: RTL and testbench

//  Parametrised successor to the 3x3 nine-segment scanner. Drives a ROWS x COLS LED matrix from a

---
 rtl/led_matrix_pkg.sv | 18 +
 rtl/led_matrix_scan_timer.sv | 33 +++
 rtl/led_matrix_scanner.sv | 89 ++++++++
 tb/tb_led_matrix_scanner.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/led_matrix_pkg.sv
// Shared defaults, counter types and row decode helper for the LED matrix scanner.
package led_matrix_pkg;

  localparam int unsigned DEF_ROWS     = 3;
  localparam int unsigned DEF_COLS     = 3;
  localparam int unsigned DEF_DWELL    = 4;
  localparam int unsigned DEF_BLANK    = 1;
  localparam int unsigned DEF_BRIGHT_W = 2;
  localparam int unsigned MAX_ROWS     = 32;

  typedef logic [((DEF_ROWS > 1) ? $clog2(DEF_ROWS) : 1)-1:0]   row_idx_t;
  typedef logic [((DEF_DWELL > 1) ? $clog2(DEF_DWELL) : 1)-1:0] dwell_cnt_t;

  function automatic logic [MAX_ROWS-1:0] onehot_row(input int unsigned idx);
    return MAX_ROWS'(1) << idx;
  endfunction

endpackage

// File: rtl/led_matrix_scan_timer.sv
// Row/dwell position counters for the matrix scan; holds position while en is low.
module led_matrix_scan_timer #(
  parameter  int unsigned ROWS  = 3,
  parameter  int unsigned DWELL = 4,
  localparam int unsigned RW    = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int unsigned DW    = (DWELL > 1) ? $clog2(DWELL) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic [RW-1:0] row_idx,
  output logic [DW-1:0] dwell_cnt,
  output logic          frame_tick
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_idx   <= '0;
      dwell_cnt <= '0;
    end else if (en) begin
      if (dwell_cnt == DW'(DWELL - 1)) begin
        dwell_cnt <= '0;
        row_idx   <= (row_idx == RW'(ROWS - 1)) ? '0 : row_idx + 1'b1;
      end else begin
        dwell_cnt <= dwell_cnt + 1'b1;
      end
    end
  end

  // Latch edge: the edge that leaves position (0,0) while scanning.
  assign frame_tick = en && (row_idx == '0) && (dwell_cnt == '0);

endmodule

// File: rtl/led_matrix_scanner.sv
// ROWS x COLS LED matrix scanner with frame-latched buffer and anti-ghost blanking.
// Optional brightness port and PWM-style window limit under LED_MATRIX_DIM_EN.
module led_matrix_scanner
  import led_matrix_pkg::*;
#(
  parameter int unsigned ROWS     = DEF_ROWS,
  parameter int unsigned COLS     = DEF_COLS,
  parameter int unsigned DWELL    = DEF_DWELL,
  parameter int unsigned BLANK    = DEF_BLANK
`ifdef LED_MATRIX_DIM_EN
  ,
  parameter int unsigned BRIGHT_W = DEF_BRIGHT_W
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [ROWS*COLS-1:0] segments,
`ifdef LED_MATRIX_DIM_EN
  input  logic [BRIGHT_W-1:0]  brightness,
`endif
  output logic [ROWS-1:0]      rows,
  output logic [COLS-1:0]      cols,
  output logic                 frame_start
);

  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned DW = (DWELL > 1) ? $clog2(DWELL) : 1;

  logic [RW-1:0]        row_idx;
  logic [DW-1:0]        dwell_cnt;
  logic                 frame_tick;
  logic [ROWS*COLS-1:0] fb;
  logic [COLS-1:0]      slice;
  logic                 in_window;
  logic [ROWS-1:0]      rows_d;
  logic [COLS-1:0]      cols_d;

  led_matrix_scan_timer #(
    .ROWS  (ROWS),
    .DWELL (DWELL)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .row_idx    (row_idx),
    .dwell_cnt  (dwell_cnt),
    .frame_tick (frame_tick)
  );

  always_comb begin
    slice = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      if (row_idx == RW'(r)) slice = fb[r*COLS +: COLS];
    end

    in_window = (dwell_cnt >= DW'(BLANK)) && (slice != '0);
`ifdef LED_MATRIX_DIM_EN
    in_window = in_window && ((32'(dwell_cnt) - BLANK) < 32'(brightness));
`endif

    rows_d = '0;
    cols_d = '1;
    if (in_window) begin
      rows_d = ROWS'(onehot_row(32'(row_idx)));
      cols_d = ~slice;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fb          <= '0;
      rows        <= '0;
      cols        <= '1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= frame_tick;
      if (frame_tick) fb <= segments;
      if (en) begin
        rows <= rows_d;
        cols <= cols_d;
      end else begin
        rows <= '0;
        cols <= '1;
      end
    end
  end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Scoreboard bench for led_matrix_scanner (3x3, DWELL=4, BLANK=1); dimming cases under LED_MATRIX_DIM_EN.
module tb_led_matrix_scanner;

  localparam int unsigned R = 3;
  localparam int unsigned C = 3;
  localparam int unsigned D = 4;
  localparam int unsigned B = 1;
  localparam int unsigned N = R * C;
  localparam int unsigned F = R * D;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         en = 1'b0;
  logic [N-1:0] segments = '0;
`ifdef LED_MATRIX_DIM_EN
  logic [1:0]   brightness = 2'd3;
`endif
  logic [R-1:0] rows;
  logic [C-1:0] cols;
  logic         frame_start;

  led_matrix_scanner #(
    .ROWS  (R),
    .COLS  (C),
    .DWELL (D),
    .BLANK (B)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .segments    (segments),
`ifdef LED_MATRIX_DIM_EN
    .brightness  (brightness),
`endif
    .rows        (rows),
    .cols        (cols),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [R-1:0] rows;
    logic [C-1:0] cols;
    logic         fs;
  } exp_t;

  exp_t         sb[$];
  int unsigned  checks = 0;
  int unsigned  errors = 0;
  int unsigned  m_pos = 0;
  logic [N-1:0] m_fb = '0;
  int unsigned  cyc = 0;
  int unsigned  last_fs = 0;
  int unsigned  period = 0;
  int unsigned  fs_count = 0;
  bit           fs_seen = 1'b0;
  int unsigned  lit_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference built on a single frame position counter rather than row/dwell pair.
  function automatic exp_t model_out();
    exp_t         e;
    int unsigned  row;
    int unsigned  d;
    logic [C-1:0] sl;
    logic [R-1:0] oh;
    bit           lit;
    e.rows = '0;
    e.cols = '1;
    e.fs   = 1'b0;
    if (en) begin
      row  = m_pos / D;
      d    = m_pos % D;
      sl   = m_fb[row*C +: C];
      e.fs = (m_pos == 0);
      lit  = (d >= B) && (sl != '0);
`ifdef LED_MATRIX_DIM_EN
      lit  = lit && ((d - B) < int'(brightness));
`endif
      if (lit) begin
        oh      = '0;
        oh[row] = 1'b1;
        e.rows  = oh;
        e.cols  = ~sl;
      end
    end
    return e;
  endfunction

  task automatic step();
    exp_t e;
    sb.push_back(model_out());
    if (en) begin
      if (m_pos == 0) m_fb = segments;
      m_pos = (m_pos + 1) % F;
    end
    @(posedge clk);
    #1;
    cyc++;
    e = sb.pop_front();
    check("rows", 32'(rows), 32'(e.rows));
    check("cols", 32'(cols), 32'(e.cols));
    check("frame_start", 32'(frame_start), 32'(e.fs));
    if (rows != '0) lit_cnt++;
    if (frame_start) begin
      if (fs_seen) period = cyc - last_fs;
      last_fs  = cyc;
      fs_seen  = 1'b1;
      fs_count++;
    end
  endtask

  task automatic steps(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step();
  endtask

  task automatic step_to(input int unsigned pos);
    for (int unsigned i = 0; i < 2 * F && m_pos != pos; i++) step();
    check("align_pos", m_pos, pos);
  endtask

  initial begin
    int unsigned fs_before;
    int unsigned guard;

    #3 rst_n = 1'b0;
    #1;
    check("rst_rows", 32'(rows), 0);
    check("rst_cols", 32'(cols), 32'h7);
    check("rst_fs", 32'(frame_start), 0);
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;

    // All segments dark for two frames.
    segments = '0;
    lit_cnt  = 0;
    steps(2 * F);
    check("dark_lit_cnt", lit_cnt, 0);

    // Single centre LED: three lit clocks in the row-1 slot.
    segments = 9'b000010000;
    lit_cnt  = 0;
    steps(F);
    check("centre_lit_cnt", lit_cnt, 3);
    check("frame_period", period, F);

    // Mid-frame segment change stays invisible until the next latch.
    segments = 9'b000000001;
    steps(F);
    step_to(6);
    segments = 9'b100000000;
    step_to(0);
    lit_cnt = 0;
    steps(F);
    check("row2_lit_cnt", lit_cnt, 3);

    // Scan pause mid row-1 slot stretches the frame by the paused clocks.
    segments = 9'b000010000;
    steps(F);
    step_to(6);
    fs_before = fs_count;
    en = 1'b0;
    steps(5);
    check("pause_no_fs", fs_count, fs_before);
    en = 1'b1;
    guard = 0;
    while (fs_count == fs_before && guard < 40) begin
      step();
      guard++;
    end
    check("pause_fs_seen", 32'(fs_count != fs_before), 1);
    check("pause_period", period, F + 5);

    // Asynchronous reset in the middle of a lit slot.
    step_to(7);
    check("pre_reset_lit", 32'(rows), 32'b010);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_rows", 32'(rows), 0);
    check("mid_rst_cols", 32'(cols), 32'h7);
    check("mid_rst_fs", 32'(frame_start), 0);
    m_pos   = 0;
    m_fb    = '0;
    fs_seen = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    lit_cnt = 0;
    steps(F);
    check("post_reset_lit_cnt", lit_cnt, 3);
    steps(F);
    check("post_reset_period", period, F);

`ifdef LED_MATRIX_DIM_EN
    step_to(0);
    brightness = 2'd1;
    lit_cnt = 0;
    steps(F);
    check("dim1_lit_cnt", lit_cnt, 1);
    brightness = 2'd0;
    lit_cnt = 0;
    steps(F);
    check("dim0_lit_cnt", lit_cnt, 0);
    brightness = 2'd3;
    lit_cnt = 0;
    steps(F);
    check("dim3_lit_cnt", lit_cnt, 3);
`endif

    check("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
